change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream stage of the vending machine controller; consumes the 10-bit change value it produces.
- Breaks the change into coins using a greedy algorithm over four coin tubes (20, 10, 5, 1).
- Releases one coin at a time to the coin ejector through a valid/ack handshake.
- Tracks the stock in each tube and reports any amount that cannot be paid.

Parameters:
- D3, 20, value of tube 3 (largest coin)
- D2, 10, value of tube 2
- D1, 5, value of tube 1
- D0, 1, value of tube 0 (smallest coin)
- INIT_STOCK, 15, coins loaded into each tube at reset and on refill
- STOCK_W, 6, width of each tube stock counter

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle strobe meaning change_in is valid; sampled in IDLE only
- change_in  in  10  amount to dispense
- refill  in  1  when high in IDLE, reloads all tubes to INIT_STOCK
- coin_ack  in  1  ejector has taken the presented coin
- coin_valid  out  1  a coin is being presented
- coin_sel  out  2  tube index of the presented coin (3 = D3 … 0 = D0)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a transaction ends
- short  out  1  last transaction could not pay the full amount
- short_amt  out  10  unpaid remainder of the last transaction
- stock_empty  out  4  bit i high when tube i stock is 0 (combinational from the counters)

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to IDLE; remaining register = 0.
  - coin_valid, coin_sel, busy, done, short, short_amt all go to 0.
  - All tube stocks go to INIT_STOCK.
  - Applies mid-transaction: the current transaction is aborted, no partial-state recovery.
- States: IDLE, SELECT, EJECT, DONE.
- IDLE:
  - start=1: remaining <= change_in; short <= 0; short_amt <= 0; next state SELECT.
  - start=1 with change_in==0: still goes to SELECT, which goes straight to DONE.
  - refill=1 and start=0: every stock <= INIT_STOCK.
  - refill=1 and start=1 together: start wins and refill is dropped.
- SELECT (no output handshake in this cycle):
  - Pick the highest tube i with Di <= remaining and stock[i] != 0.
  - Tube found: coin_sel <= i; coin_valid <= 1; next state EJECT.
  - No tube found and remaining==0: next state DONE.
  - No tube found and remaining!=0: short <= 1; short_amt <= remaining; next state DONE.
- EJECT:
  - coin_valid and coin_sel are held stable until coin_ack=1 is sampled.
  - On the ack edge: remaining <= remaining - D[coin_sel]; stock[coin_sel] <= stock[coin_sel] - 1; coin_valid <= 0; next state SELECT.
  - coin_ack while coin_valid=0 is ignored.
- DONE:
  - done=1 for exactly this one cycle; next state IDLE.
  - short and short_amt hold their values until the next accepted start or reset.
- Ignored inputs:
  - start in any state other than IDLE is ignored; it is not queued.
  - refill outside IDLE is ignored.
- Timing:
  - Each coin costs 2 cycles minimum (SELECT + EJECT with immediate ack).
  - With ack tied high, done is high 2N+1 cycles after the edge that samples start, for N coins.
- Arithmetic:
  - remaining is 10 bits unsigned.
  - Subtraction never underflows because Di <= remaining is checked in SELECT.
  - Stock counters never decrement below 0, because an empty tube is never selected.

Test Plan:
- Nominal greedy split: change_in=37, all stocks 15, coin_ack tied high.
  - coin_sel sequence 3,2,1,0,0; done 11 cycles after start; short=0.
  - Stocks afterwards: 14,14,14,13 (tubes 3,2,1,0).
- Backpressure: change_in=5, coin_ack held low 3 cycles then high.
  - coin_valid=1 and coin_sel=1 stable across all 4 EJECT cycles; exactly one coin; tube 1 stock decrements once.
- Tube exhaustion with INIT_STOCK=2: change_in=97.
  - Coins 20,20,10,10,5,5,1,1 (72 total); short=1; short_amt=25; stock_empty=4'b1111.
  - Then refill=1 in IDLE: stock_empty returns to 0; a following change_in=25 pays out 20,5.
- Zero / ignored start: change_in=0 with start: no coin_valid; done pulses 2 cycles later; short=0.
  - A start pulse during EJECT of another transaction causes no change to remaining.
- Reset mid-operation: reset=0 while coin_valid=1 in a 37 transaction.
  - Next cycle coin_valid=0, busy=0, done=0, short=0, all stocks=INIT_STOCK.
  - A fresh start with 37 behaves exactly as the first scenario.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Coin ejector handshake between the change dispenser and the ejector.
// master drives coin_valid/coin_sel, slave returns coin_ack.
interface change_dispenser_if;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       coin_ack;

    modport master (
        output coin_valid,
        output coin_sel,
        input  coin_ack
    );

    modport slave (
        input  coin_valid,
        input  coin_sel,
        output coin_ack
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: splits change_in over four tubes (D3..D0) and
// ejects one coin per valid/ack handshake, tracking per-tube stock.
// Ports: clk, reset (sync, active-low), start/change_in (new amount),
// refill (reload tubes in IDLE), coin (ejector handshake, master side),
// busy/done (status), short/short_amt (unpaid remainder), stock_empty.
module change_dispenser #(
    parameter int D3         = 20,
    parameter int D2         = 10,
    parameter int D1         = 5,
    parameter int D0         = 1,
    parameter int INIT_STOCK = 15,
    parameter int STOCK_W    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [9:0]          change_in,
    input  logic                refill,
    change_dispenser_if.master  coin,
    output logic                busy,
    output logic                done,
    output logic                short,
    output logic [9:0]          short_amt,
    output logic [3:0]          stock_empty
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [STOCK_W-1:0] INIT_S = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] ONE_S  = STOCK_W'(1);

    state_e             state_q, state_d;
    logic [9:0]         rem_q, rem_d;
    logic               coin_valid_q, coin_valid_d;
    logic [1:0]         coin_sel_q, coin_sel_d;
    logic               short_q, short_d;
    logic [9:0]         short_amt_q, short_amt_d;
    logic [STOCK_W-1:0] stock_q [4];
    logic [STOCK_W-1:0] stock_d [4];

    logic               found;
    logic [1:0]         pick;

    function automatic logic [9:0] denom(input logic [1:0] idx);
        logic [9:0] v;
        unique case (idx)
            2'd3:    v = 10'(D3);
            2'd2:    v = 10'(D2);
            2'd1:    v = 10'(D1);
            default: v = 10'(D0);
        endcase
        return v;
    endfunction

    // Ascending scan so the highest eligible tube overwrites lower ones.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (denom(2'(i)) <= rem_q && stock_q[i] != '0) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            coin_valid_q <= 1'b0;
            coin_sel_q   <= 2'd0;
            short_q      <= 1'b0;
            short_amt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= INIT_S;
            end
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            coin_valid_q <= coin_valid_d;
            coin_sel_q   <= coin_sel_d;
            short_q      <= short_d;
            short_amt_q  <= short_amt_d;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        coin_valid_d = coin_valid_q;
        coin_sel_d   = coin_sel_q;
        short_d      = short_q;
        short_amt_d  = short_amt_q;
        for (int i = 0; i < 4; i++) begin
            stock_d[i] = stock_q[i];
        end

        unique case (state_q)
            IDLE: begin
                // start has priority; a simultaneous refill is dropped
                if (start) begin
                    rem_d       = change_in;
                    short_d     = 1'b0;
                    short_amt_d = '0;
                    state_d     = SELECT;
                end else if (refill) begin
                    for (int i = 0; i < 4; i++) begin
                        stock_d[i] = INIT_S;
                    end
                end
            end
            SELECT: begin
                if (found) begin
                    coin_sel_d   = pick;
                    coin_valid_d = 1'b1;
                    state_d      = EJECT;
                end else begin
                    if (rem_q != '0) begin
                        short_d     = 1'b1;
                        short_amt_d = rem_q;
                    end
                    state_d = DONE;
                end
            end
            EJECT: begin
                // selection guaranteed denom <= rem and stock != 0
                if (coin.coin_ack && coin_valid_q) begin
                    rem_d               = rem_q - denom(coin_sel_q);
                    stock_d[coin_sel_q] = stock_q[coin_sel_q] - ONE_S;
                    coin_valid_d        = 1'b0;
                    state_d             = SELECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        coin.coin_valid = coin_valid_q;
        coin.coin_sel   = coin_sel_q;
        short           = short_q;
        short_amt       = short_amt_q;
        stock_empty     = '0;
        for (int i = 0; i < 4; i++) begin
            stock_empty[i] = (stock_q[i] == '0);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of greedy transactions plus
// hand-written backpressure, exhaustion/refill and reset sequences.
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] change_in;
    logic       refill;
    logic       ack;

    int tests = 0;
    int fails = 0;

    change_dispenser_if ca ();
    change_dispenser_if cb ();
    assign ca.coin_ack = ack;
    assign cb.coin_ack = ack;

    logic       a_busy, a_done, a_short;
    logic [9:0] a_amt;
    logic [3:0] a_empty;
    logic       b_busy, b_done, b_short;
    logic [9:0] b_amt;
    logic [3:0] b_empty;

    change_dispenser dut_a (
        .clk(clk), .reset(reset), .start(start),
        .change_in(change_in), .refill(refill), .coin(ca),
        .busy(a_busy), .done(a_done), .short(a_short),
        .short_amt(a_amt), .stock_empty(a_empty)
    );

    change_dispenser #(.INIT_STOCK(2)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .change_in(change_in), .refill(refill), .coin(cb),
        .busy(b_busy), .done(b_done), .short(b_short),
        .short_amt(b_amt), .stock_empty(b_empty)
    );

    bit         mon_b;
    logic       m_valid, m_done, m_busy, m_short;
    logic [1:0] m_sel;
    logic [9:0] m_amt;
    logic [3:0] m_empty;

    always_comb begin
        if (mon_b) begin
            m_valid = cb.coin_valid; m_sel = cb.coin_sel;
            m_done = b_done; m_busy = b_busy;
            m_short = b_short; m_amt = b_amt; m_empty = b_empty;
        end else begin
            m_valid = ca.coin_valid; m_sel = ca.coin_sel;
            m_done = a_done; m_busy = a_busy;
            m_short = a_short; m_amt = a_amt; m_empty = a_empty;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int coin_val(input logic [1:0] s);
        case (s)
            2'd3:    return 20;
            2'd2:    return 10;
            2'd1:    return 5;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; refill = 1'b0; ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // cyc counts rising edges after the edge that samples start.
    task automatic do_txn(input logic [9:0] amt, input int hold,
                          input bit inj, output int n, output int paid,
                          output int cyc, output int bad_order,
                          output int maxw, output int unstable,
                          output logic [1:0] lsel);
        int w;
        int last;
        logic [1:0] s0;
        n = 0; paid = 0; cyc = 0; bad_order = 0; maxw = 0;
        unstable = 0; w = 0; last = 3; s0 = 2'd0; lsel = 2'd0;
        ack = (hold == 0);
        @(negedge clk);
        start = 1'b1; change_in = amt;
        @(negedge clk);
        start = 1'b0;
        while (!m_done && cyc < 400) begin
            start = 1'b0;
            if (m_valid) begin
                if (w == 0) s0 = m_sel;
                else if (m_sel !== s0) unstable++;
                w++;
                if (w > maxw) maxw = w;
                if (inj && w == 1 && hold > 0) begin
                    start = 1'b1; change_in = 10'd10;
                end
                if (w > hold) begin
                    ack = 1'b1; n++; paid += coin_val(m_sel);
                    if (int'(m_sel) > last) bad_order++;
                    last = int'(m_sel); lsel = m_sel; w = 0;
                end else begin
                    ack = 1'b0;
                end
            end else begin
                ack = (hold == 0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ack = 1'b1;
        chk("done_seen", 32'(m_done), 32'd1);
    endtask

    typedef struct {
        logic [9:0] amt;
        int         n;
        int         paid;
        logic       sh;
        logic [9:0] sa;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n, paid, cyc, bad, maxw, unst;
        logic [1:0] lsel;

        tbl[0] = '{10'd37,   5,  37, 1'b0, 10'd0};
        tbl[1] = '{10'd0,    0,   0, 1'b0, 10'd0};
        tbl[2] = '{10'd1,    1,   1, 1'b0, 10'd0};
        tbl[3] = '{10'd64,   7,  64, 1'b0, 10'd0};
        tbl[4] = '{10'd19,   6,  19, 1'b0, 10'd0};
        tbl[5] = '{10'd1023, 60, 540, 1'b1, 10'd483};

        mon_b = 1'b0;
        reset = 1'b0; start = 1'b0; change_in = '0;
        refill = 1'b0; ack = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(ca.coin_valid), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_short", 32'(a_short), 0);
        chk("rst_amt", 32'(a_amt), 0);
        chk("rst_empty", 32'(a_empty), 0);
        chk("rst_stock3", 32'(dut_a.stock_q[3]), 15);
        chk("rst_stock0", 32'(dut_a.stock_q[0]), 15);
        reset = 1'b1;

        // Greedy table, ack tied high, fresh stock each time
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            do_txn(tbl[i].amt, 0, 1'b0, n, paid, cyc, bad, maxw, unst, lsel);
            chk("tbl_coins", n, tbl[i].n);
            chk("tbl_paid", paid, tbl[i].paid);
            chk("tbl_cycles", cyc, 2 * tbl[i].n + 1);
            chk("tbl_order", bad, 0);
            chk("tbl_short", 32'(m_short), 32'(tbl[i].sh));
            chk("tbl_short_amt", 32'(m_amt), 32'(tbl[i].sa));
            @(negedge clk);
            chk("tbl_done_pulse", 32'(m_done), 0);
            chk("tbl_idle", 32'(m_busy), 0);
        end

        // Backpressure: ack held low for 3 EJECT cycles
        reset_dut();
        do_txn(10'd5, 3, 1'b0, n, paid, cyc, bad, maxw, unst, lsel);
        chk("bp_coins", n, 1);
        chk("bp_valid_cycles", maxw, 4);
        chk("bp_stable", unst, 0);
        chk("bp_sel", 32'(lsel), 1);
        chk("bp_cycles", cyc, 6);
        chk("bp_stock1", 32'(dut_a.stock_q[1]), 14);

        // start during EJECT must be ignored
        reset_dut();
        do_txn(10'd5, 2, 1'b1, n, paid, cyc, bad, maxw, unst, lsel);
        chk("ign_coins", n, 1);
        chk("ign_paid", paid, 5);
        chk("ign_cycles", cyc, 5);
        chk("ign_short", 32'(a_short), 0);

        // Exhaustion on the 2-coin tubes, then refill
        reset_dut();
        mon_b = 1'b1;
        do_txn(10'd97, 0, 1'b0, n, paid, cyc, bad, maxw, unst, lsel);
        chk("ex_coins", n, 8);
        chk("ex_paid", paid, 72);
        chk("ex_short", 32'(m_short), 1);
        chk("ex_short_amt", 32'(m_amt), 25);
        chk("ex_empty", 32'(m_empty), 32'hf);
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        chk("refill_empty", 32'(m_empty), 0);
        do_txn(10'd25, 0, 1'b0, n, paid, cyc, bad, maxw, unst, lsel);
        chk("rf_coins", n, 2);
        chk("rf_paid", paid, 25);
        chk("rf_short", 32'(m_short), 0);
        mon_b = 1'b0;

        // Reset while a coin is presented
        reset_dut();
        @(negedge clk);
        start = 1'b1; change_in = 10'd37;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && !ca.coin_valid; k++) @(negedge clk);
        chk("mid_valid_seen", 32'(ca.coin_valid), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_valid", 32'(ca.coin_valid), 0);
        chk("mid_busy", 32'(a_busy), 0);
        chk("mid_done", 32'(a_done), 0);
        chk("mid_short", 32'(a_short), 0);
        for (int i = 0; i < 4; i++)
            chk("mid_stock", 32'(dut_a.stock_q[i]), 15);
        reset = 1'b1;
        do_txn(10'd37, 0, 1'b0, n, paid, cyc, bad, maxw, unst, lsel);
        chk("re_coins", n, 5);
        chk("re_paid", paid, 37);
        chk("re_cycles", cyc, 11);
        chk("re_short", 32'(a_short), 0);
        chk("re_stock3", 32'(dut_a.stock_q[3]), 14);
        chk("re_stock2", 32'(dut_a.stock_q[2]), 14);
        chk("re_stock1", 32'(dut_a.stock_q[1]), 14);
        chk("re_stock0", 32'(dut_a.stock_q[0]), 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
